// File: rtl/memory_write.sv
// Write-side memory access: stores one multi-word entry word by word into the kernel or
// picture RAM, then raises HANDSHAKE until the requester drops ENABLE.
module memory_write #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned WORDS  = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic [2:0]              CTRL,
    input  logic [ADDR_W-1:0]       ADDRESS,
    input  logic [WORDS*WORD_W-1:0] DATA,
    output logic                    HANDSHAKE,
    output logic                    BUSY,
    output logic [ADDR_W-1:0]       MEM_ADDRESS,
    output logic [WORD_W-1:0]       MEM_DATA,
    output logic                    MEM_WREN,
    output logic                    MEM_SEL
);

    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [WORDS*WORD_W-1:0] data_q, data_d;
    logic                    sel_q, sel_d;

    logic                    handshake_q, handshake_d;
    logic                    busy_q, busy_d;
    logic [ADDR_W-1:0]       mem_address_q, mem_address_d;
    logic [WORD_W-1:0]       mem_data_q, mem_data_d;
    logic                    mem_wren_q, mem_wren_d;
    logic                    mem_sel_q, mem_sel_d;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        n_d           = n_q;
        base_d        = base_q;
        data_d        = data_q;
        sel_d         = sel_q;
        handshake_d   = 1'b0;
        mem_wren_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_sel_d     = mem_sel_q;

        unique case (state_q)
            StIdle: begin
                if (ENABLE) begin
                    data_d  = DATA;
                    sel_d   = CTRL[2];
                    // A zero word count means a full entry, so a request always writes.
                    n_d     = (CTRL[1:0] == 2'd0) ? CNT_W'(WORDS) : CNT_W'(CTRL[1:0]);
                    base_d  = ADDRESS * ADDR_W'(WORDS);
                    k_d     = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!ENABLE) begin
                    state_d = StIdle;
                end else begin
                    mem_wren_d    = 1'b1;
                    mem_address_d = base_q + ADDR_W'(k_q);
                    mem_data_d    = data_q[WORD_W*int'(k_q) +: WORD_W];
                    mem_sel_d     = sel_q;
                    k_d           = k_q + 1'b1;
                    if (k_q == n_q - 1'b1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (ENABLE) begin
                    handshake_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StWrite);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= StIdle;
            k_q           <= '0;
            n_q           <= '0;
            base_q        <= '0;
            data_q        <= '0;
            sel_q         <= 1'b0;
            handshake_q   <= 1'b0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            mem_sel_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            n_q           <= n_d;
            base_q        <= base_d;
            data_q        <= data_d;
            sel_q         <= sel_d;
            handshake_q   <= handshake_d;
            busy_q        <= busy_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            mem_sel_q     <= mem_sel_d;
        end
    end

    assign HANDSHAKE   = handshake_q;
    assign BUSY        = busy_q;
    assign MEM_ADDRESS = mem_address_q;
    assign MEM_DATA    = mem_data_q;
    assign MEM_WREN    = mem_wren_q;
    assign MEM_SEL     = mem_sel_q;

endmodule
